// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: byte write or random read (Sr) to one fixed 7-bit target.
// Open-drain SCL/SDA, open-loop SCL, one SCL bit = 4*CLK_DIV clocks.
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV  = 16,
  parameter logic [6:0]  DEV_ADDR = 7'h50
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wr_data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic [7:0] rd_data_o,
  output logic       i2c_scl_o,
  inout  wire        i2c_sda_io
);

  if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("CLK_DIV must be within 4..255");
  end

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] WR_ID    = {DEV_ADDR, 1'b0};
  localparam logic [7:0] RD_ID    = {DEV_ADDR, 1'b1};

  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_ACK, STOP, DONE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       rw_q, rw_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] data_q, data_d;
  logic       nack_q, nack_d;
  logic       ack_err_q, ack_err_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       scl_low_q, scl_low_d;
  logic       sda_low_q, sda_low_d;
  logic       sda_meta_q, sda_meta_d;
  logic       sda_sync_q, sda_sync_d;

  logic quarter_end;
  logic sample_pt;
  logic bit_end;

  // Byte index meaning: 0 = write ID, 1 = register, 2 = write data, 3 = read ID.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rw_d       = rw_q;
    reg_d      = reg_q;
    data_d     = data_q;
    nack_d     = nack_q;
    ack_err_d  = ack_err_q;
    rd_data_d  = rd_data_q;
    sda_meta_d = i2c_sda_io;
    sda_sync_d = sda_meta_q;

    quarter_end = (div_q == DIV_LAST);
    sample_pt   = quarter_end && (ph_q == 2'd2);
    bit_end     = quarter_end && (ph_q == 2'd3);

    if (state_q != IDLE && state_q != DONE) begin
      div_d = quarter_end ? 8'd0 : div_q + 8'd1;
      if (quarter_end) begin
        ph_d = ph_q + 2'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = START;
          div_d     = 8'd0;
          ph_d      = 2'd0;
          bit_d     = 3'd0;
          byte_d    = 2'd0;
          tx_d      = WR_ID;
          rw_d      = rw_i;
          reg_d     = reg_addr_i;
          data_d    = wr_data_i;
          ack_err_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = TX_BYTE;
          bit_d   = 3'd0;
        end
      end
      TX_BYTE: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = RX_ACK;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
      end
      RX_ACK: begin
        if (sample_pt) begin
          nack_d = sda_sync_q;
        end
        if (bit_end) begin
          bit_d = 3'd0;
          if (nack_q) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else begin
            case (byte_q)
              2'd0: begin
                tx_d    = reg_q;
                byte_d  = 2'd1;
                state_d = TX_BYTE;
              end
              2'd1: begin
                if (rw_q) begin
                  state_d = RSTART;
                end else begin
                  tx_d    = data_q;
                  byte_d  = 2'd2;
                  state_d = TX_BYTE;
                end
              end
              2'd2:    state_d = STOP;
              default: state_d = RX_BYTE;
            endcase
          end
        end
      end
      RSTART: begin
        if (bit_end) begin
          state_d = TX_BYTE;
          tx_d    = RD_ID;
          byte_d  = 2'd3;
          bit_d   = 3'd0;
        end
      end
      RX_BYTE: begin
        if (sample_pt) begin
          rx_d = {rx_q[6:0], sda_sync_q};
        end
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = TX_ACK;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      TX_ACK: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = DONE;
          if (rw_q && !ack_err_q) begin
            rd_data_d = rx_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        div_d   = 8'd0;
        ph_d    = 2'd0;
      end
      default: state_d = IDLE;
    endcase

    // Line drives are derived from the next state so they change on the same edge as the FSM.
    busy_d    = (state_d != IDLE) && (state_d != DONE);
    done_d    = (state_d == DONE);
    scl_low_d = 1'b0;
    sda_low_d = 1'b0;
    case (state_d)
      START: begin
        scl_low_d = ph_d[1];
        sda_low_d = 1'b1;
      end
      TX_BYTE: begin
        scl_low_d = (ph_d == 2'd0) || (ph_d == 2'd3);
        sda_low_d = !tx_d[7];
      end
      RX_ACK, RX_BYTE, TX_ACK: begin
        scl_low_d = (ph_d == 2'd0) || (ph_d == 2'd3);
      end
      RSTART: begin
        scl_low_d = (ph_d == 2'd0) || (ph_d == 2'd3);
        sda_low_d = ph_d[1];
      end
      STOP: begin
        scl_low_d = (ph_d == 2'd0);
        sda_low_d = (ph_d != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= 8'd0;
      ph_q       <= 2'd0;
      bit_q      <= 3'd0;
      byte_q     <= 2'd0;
      tx_q       <= 8'd0;
      rx_q       <= 8'd0;
      rw_q       <= 1'b0;
      reg_q      <= 8'd0;
      data_q     <= 8'd0;
      nack_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      rd_data_q  <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      scl_low_q  <= 1'b0;
      sda_low_q  <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rw_q       <= rw_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      nack_q     <= nack_d;
      ack_err_q  <= ack_err_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      scl_low_q  <= scl_low_d;
      sda_low_q  <= sda_low_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ack_err_o  = ack_err_q;
  assign rd_data_o  = rd_data_q;
  assign i2c_scl_o  = scl_low_q ? 1'b0 : 1'bz;
  assign i2c_sda_io = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl (CLK_DIV=4) with a behavioural EEPROM-style target
// that logs bus bytes, START/STOP events and SCL periods.
module tb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rw;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  wire        busy;
  wire        done;
  wire        ack_err;
  wire  [7:0] rd_data;
  wire        scl_bus;
  wire        sda_bus;

  pullup (scl_bus);
  pullup (sda_bus);

  bit t_drive = 1'b0;
  assign sda_bus = t_drive ? 1'b0 : 1'bz;

  i2c_master_ctrl #(.CLK_DIV(4), .DEV_ADDR(7'h50)) dut (
    .clk_i      (clk),
    .rst        (rst),
    .start_i    (start),
    .rw_i       (rw),
    .reg_addr_i (reg_addr),
    .wr_data_i  (wr_data),
    .busy_o     (busy),
    .done_o     (done),
    .ack_err_o  (ack_err),
    .rd_data_o  (rd_data),
    .i2c_scl_o  (scl_bus),
    .i2c_sda_io (sda_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Target model state and bus observations
  logic [7:0] mem [0:255];
  logic [7:0] log_b [0:7];
  logic [6:0] tgt_addr = 7'h50;
  logic [7:0] t_sh = 8'h00;
  logic [7:0] t_ptr = 8'h00;
  int  t_bit = 0;
  int  t_byte = 0;
  int  t_mode = 0;
  bit  t_isread = 1'b0;
  bit  m_nack = 1'b0;
  int  nlog = 0;
  int  start_cnt = 0;
  int  stop_cnt = 0;
  int  glitch_cnt = 0;
  int  done_cnt = 0;
  int  per_min = 1000;
  int  per_max = 0;
  int  last_rise = 0;
  int  cyc = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rw_v, input logic [7:0] reg_v, input logic [7:0] data_v);
    @(negedge clk);
    rw       = rw_v;
    reg_addr = reg_v;
    wr_data  = data_v;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic waitDone(input string tag, output int waited);
    bit seen;
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      waited++;
      if (done) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  task automatic clearLog();
    nlog       = 0;
    start_cnt  = 0;
    stop_cnt   = 0;
    glitch_cnt = 0;
    per_min    = 1000;
    per_max    = 0;
    m_nack     = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  // Behavioural target, sampled on the falling clock edge
  initial begin
    bit scl_p, sda_p, scl_n, sda_n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    scl_p = 1'b1;
    sda_p = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      scl_n = scl_bus;
      sda_n = sda_bus;
      if ((scl_n != scl_p) && (sda_n != sda_p)) glitch_cnt++;
      if (scl_n && scl_p && sda_p && !sda_n) begin
        start_cnt++;
        t_mode = 1; t_bit = 0; t_byte = 0; t_drive = 1'b0; t_isread = 1'b0;
      end else if (scl_n && scl_p && !sda_p && sda_n) begin
        stop_cnt++;
        t_mode = 0; t_drive = 1'b0;
      end else if (scl_n && !scl_p) begin
        if (t_bit != 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        if (t_mode == 1 && t_bit < 8) t_sh = {t_sh[6:0], sda_n};
        if (t_mode == 2 && t_bit == 8) m_nack = sda_n;
        t_bit++;
      end else if (!scl_n && scl_p) begin
        if (t_mode == 1 && t_bit == 8) begin
          if (nlog < 8) log_b[nlog] = t_sh;
          nlog++;
          if (t_byte == 0) begin
            if (t_sh[7:1] == tgt_addr) begin
              t_isread = t_sh[0];
              t_drive  = 1'b1;
            end else begin
              t_mode = 0;
            end
          end else if (t_byte == 1) begin
            t_ptr   = t_sh;
            t_drive = 1'b1;
          end else begin
            mem[t_ptr] = t_sh;
            t_ptr      = t_ptr + 8'd1;
            t_drive    = 1'b1;
          end
        end else if (t_mode == 2 && t_bit == 8) begin
          t_drive = 1'b0;
        end else if (t_bit == 9) begin
          t_drive = 1'b0;
          t_bit   = 0;
          if (t_mode == 1 && t_isread && t_byte == 0) begin
            t_mode  = 2;
            t_sh    = mem[t_ptr];
            t_drive = !t_sh[7];
          end else if (t_mode == 2) begin
            if (m_nack) begin
              t_mode = 0;
            end else begin
              t_ptr   = t_ptr + 8'd1;
              t_sh    = mem[t_ptr];
              t_drive = !t_sh[7];
            end
          end
          t_byte++;
        end else if (t_mode == 2 && t_bit >= 1 && t_bit <= 7) begin
          t_drive = !t_sh[7 - t_bit];
        end
      end
      scl_p = scl_n;
      sda_p = sda_n;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    int stops_before;
    rst = 1'b1; start = 1'b0; rw = 1'b0; reg_addr = 8'h00; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",    32'(busy),    32'd0);
    checkOutput("reset_done",    32'(done),    32'd0);
    checkOutput("reset_ack_err", 32'(ack_err), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'h00);
    checkOutput("reset_scl",     32'(scl_bus), 32'd1);
    checkOutput("reset_sda",     32'(sda_bus), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] byte write 0x5A -> reg 0x10");
    clearLog();
    done_cnt = 0;
    applyStimulus(1'b0, 8'h10, 8'h5A);
    checkOutput("wr_busy_after_start", 32'(busy), 32'd1);
    repeat (40) @(negedge clk);
    rw = 1'b0; reg_addr = 8'h77; wr_data = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("wr_done_seen", waited);
    checkOutput("wr_ack_err",     32'(ack_err), 32'd0);
    checkOutput("wr_busy_at_done", 32'(busy),   32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_at_done_ignored", 32'(busy), 32'd0);
    repeat (200) @(negedge clk);
    checkOutput("wr_done_count",     32'(done_cnt),   32'd1);
    checkOutput("wr_mem_10",         32'(mem[8'h10]), 32'h5A);
    checkOutput("busy_start_ignored", 32'(mem[8'h77]), 32'h00);
    checkOutput("wr_nbytes",         32'(nlog),       32'd3);
    checkOutput("wr_byte0",          32'(log_b[0]),   32'hA0);
    checkOutput("wr_byte1",          32'(log_b[1]),   32'h10);
    checkOutput("wr_byte2",          32'(log_b[2]),   32'h5A);
    checkOutput("wr_starts",         32'(start_cnt),  32'd1);
    checkOutput("wr_stops",          32'(stop_cnt),   32'd1);
    checkOutput("scl_period_min",    32'(per_min),    32'd16);
    checkOutput("scl_period_max",    32'(per_max),    32'd16);
    checkOutput("wr_sda_scl_same_edge", 32'(glitch_cnt), 32'd0);

    $display("[TB] random read reg 0x10 (holds 0xC3)");
    mem[8'h10] = 8'hC3;
    clearLog();
    applyStimulus(1'b1, 8'h10, 8'h00);
    waitDone("rd_done_seen", waited);
    checkOutput("rd_data",      32'(rd_data),    32'hC3);
    checkOutput("rd_ack_err",   32'(ack_err),    32'd0);
    repeat (20) @(negedge clk);
    checkOutput("rd_nbytes",    32'(nlog),       32'd3);
    checkOutput("rd_byte0",     32'(log_b[0]),   32'hA0);
    checkOutput("rd_byte1",     32'(log_b[1]),   32'h10);
    checkOutput("rd_byte2",     32'(log_b[2]),   32'hA1);
    checkOutput("rd_starts",    32'(start_cnt),  32'd2);
    checkOutput("rd_stops",     32'(stop_cnt),   32'd1);
    checkOutput("rd_master_nack", 32'(m_nack),   32'd1);
    checkOutput("rd_sda_scl_same_edge", 32'(glitch_cnt), 32'd0);

    $display("[TB] address NACK (target at 0x51)");
    tgt_addr = 7'h51;
    clearLog();
    applyStimulus(1'b0, 8'h20, 8'h77);
    waitDone("nack_done_seen", waited);
    checkOutput("nack_ack_err",  32'(ack_err),    32'd1);
    checkOutput("nack_rd_data",  32'(rd_data),    32'hC3);
    checkOutput("nack_duration", 32'(waited),     32'd176);
    repeat (20) @(negedge clk);
    checkOutput("nack_nbytes",   32'(nlog),       32'd1);
    checkOutput("nack_stops",    32'(stop_cnt),   32'd1);
    checkOutput("nack_mem_20",   32'(mem[8'h20]), 32'h00);
    checkOutput("nack_err_holds", 32'(ack_err),   32'd1);

    $display("[TB] reset in the middle of a write");
    tgt_addr = 7'h50;
    applyStimulus(1'b0, 8'h30, 8'h3C);
    checkOutput("ack_err_cleared_on_start", 32'(ack_err), 32'd0);
    repeat (60) @(negedge clk);
    for (int i = 0; i < 40 && scl_bus; i++) @(negedge clk);
    checkOutput("scl_low_before_reset", 32'(scl_bus), 32'd0);
    stops_before = stop_cnt;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_scl",     32'(scl_bus), 32'd1);
    checkOutput("midrst_sda",     32'(sda_bus), 32'd1);
    checkOutput("midrst_busy",    32'(busy),    32'd0);
    checkOutput("midrst_rd_data", 32'(rd_data), 32'h00);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("midrst_no_stop", 32'(stop_cnt),   32'(stops_before));
    checkOutput("midrst_mem_30",  32'(mem[8'h30]), 32'h00);
    applyStimulus(1'b0, 8'h30, 8'h3C);
    waitDone("post_rst_done_seen", waited);
    checkOutput("post_rst_ack_err", 32'(ack_err),    32'd0);
    checkOutput("post_rst_mem_30",  32'(mem[8'h30]), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk_i cycles per SCL quarter-period; legal range 4..255.
REQ-002 SHALL have parameter DEV_ADDR, default 7'h50: 7-bit target address; write ID 8'hA0, read ID 8'hA1.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start_i, input, 1: one-cycle request; sampled only when busy_o=0.
REQ-006 SHALL have port rw_i, input, 1: 0 = byte write, 1 = random read; captured with start_i.
REQ-007 SHALL have port reg_addr_i, input, 8: target register address; captured with start_i.
REQ-008 SHALL have port wr_data_i, input, 8: write byte; captured with start_i.
REQ-009 SHALL have port busy_o, output, 1: high from the cycle after accepted start_i until the cycle done_o pulses.
REQ-010 SHALL have port done_o, output, 1: one-cycle pulse at transaction end.
REQ-011 SHALL have port ack_err_o, output, 1: valid with done_o; 1 = target NACKed.
REQ-012 SHALL have port rd_data_o, output, 8: read byte; updated only at done_o of an error-free read.
REQ-013 SHALL have port i2c_scl_o, output, 1: open-drain SCL, drives 1'b0 or 1'bz.
REQ-014 SHALL have port i2c_sda_io, inout, 1: open-drain SDA, drives 1'b0 or 1'bz.

Function
REQ-015 SHALL use a divider counter 0..CLK_DIV-1 and a 2-bit phase; one SCL bit = 4*CLK_DIV clocks: ph0 SCL low and SDA updated; ph1 SCL released; ph2 SCL high; ph3 SCL low.
REQ-016 SHALL sample SDA through a 2-flop synchronizer on the last clock of ph2.
REQ-017 SHALL implement FSM states IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_ACK, STOP, DONE.
REQ-018 SHALL on START hold SCL released, drop SDA for 2*CLK_DIV clocks, then drive SCL low.
REQ-019 SHALL shift TX_BYTE MSB first, 8 bits, then RX_ACK with SDA released; sampled 1 means NACK.
REQ-020 SHALL on a write send the sequence A0, reg_addr, data, then STOP.
REQ-021 SHALL on a read send A0, reg_addr, RSTART (SDA released during SCL low, SCL released, SDA dropped while SCL high), A1, RX_BYTE of 8 bits MSB first, then TX_ACK driving NACK (SDA released), then STOP.
REQ-022 SHALL on any NACK set ack_err_o and go directly to STOP, skipping the remaining bytes.
REQ-023 SHALL on STOP drive SDA low during SCL low, release SCL, and release SDA 2*CLK_DIV clocks later.
REQ-024 SHALL after STOP enter DONE for one cycle: pulse done_o, drop busy_o, return to IDLE.
REQ-025 SHALL ignore start_i while busy_o=1; a start_i in the same cycle as done_o SHALL also be ignored.
REQ-026 SHALL clear ack_err_o when a new start_i is accepted; otherwise it holds its last value.
REQ-027 SHALL keep the bit counter at 3 bits and wrap after bit 7 without leaking into the next byte.
REQ-028 SHALL not support clock stretching; SCL is open-loop.

Reset
REQ-029 SHALL on rst=1 at a clock edge release SCL and SDA (z), set FSM to IDLE, and clear the divider, phase and bit counters.
REQ-030 SHALL on reset also set busy_o=0, done_o=0, ack_err_o=0 and rd_data_o=8'h00.
REQ-031 SHALL, when reset is asserted mid-transaction, release both lines on the next edge with no STOP generated.

Verification
REQ-032 Write, with an ACKing target model at 0x50: rw=0, reg=8'h10, data=8'h5A -> bus shows A0/ACK, 10/ACK, 5A/ACK, STOP; done_o pulses once; ack_err_o=0; the target holds 8'h5A at address 8'h10.
REQ-033 Read: preload target address 8'h10=8'hC3, rw=1, reg=8'h10 -> bus shows A0, 10, Sr, A1, C3, master NACK, STOP; rd_data_o=8'hC3; ack_err_o=0.
REQ-034 Address NACK, target at 0x51: write request -> NACK after A0, STOP follows immediately, ack_err_o=1, rd_data_o unchanged.
REQ-035 Timing, CLK_DIV=4: SCL period measures 16 clk_i cycles; SDA is stable whenever SCL is high, except at START/Sr/STOP.
REQ-036 Busy/reset: a second start_i during busy is ignored (exactly one done_o); rst asserted mid-byte -> SCL=z, SDA=z and busy_o=0 on the next edge, and a new write then completes normally.
